// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Interlock / forwarding controller for the 5-stage RV32I pipeline.
//   Tracks M/W destinations in shadow registers, drives execute-stage
//   forwarding muxes, stalls/flushes F/D/E and freezes the whole pipe while
//   data memory is busy, with a watchdog on that wait.
//   Optional feature macro: HAZARD_FORWARD_EN (undefined = no forwarding,
//   decode interlocks on every in-flight writer instead).
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D_i,
  input  logic [4:0]           Rs2D_i,
  input  logic [4:0]           Rs1E_i,
  input  logic [4:0]           Rs2E_i,
  input  logic [4:0]           RdE_i,
  input  logic                 RegWriteE_i,
  input  logic [1:0]           ResultSrcE_i,
  input  logic                 PCSrcE_i,
  input  logic                 MemReqM_i,
  input  logic                 MemReadyM_i,
  output logic [1:0]           ForwardAE_o,
  output logic [1:0]           ForwardBE_o,
  output logic                 StallF_o,
  output logic                 StallD_o,
  output logic                 StallE_o,
  output logic                 StallM_o,
  output logic                 StallW_o,
  output logic                 FlushD_o,
  output logic                 FlushE_o,
  output logic [CNT_WIDTH-1:0] StallCount_o,
  output logic [CNT_WIDTH-1:0] FlushCount_o,
  output logic                 MemTimeout_o
);

  // Wide enough to hold MEM_TIMEOUT plus one increment without overflow.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_inc;
  logic              memstall;
  logic              data_hazard;
  logic [4:0]        rd_m;
  logic [4:0]        rd_w;
  logic              reg_write_m;
  logic              reg_write_w;

  assign wait_cnt_inc = wait_cnt + WAIT_ONE;

  // Global memory stall: a fresh unready access, a continuing wait, or a dead unit.
  always_comb begin
    memstall = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN:      memstall = MemReqM_i & ~MemReadyM_i;
        ST_MEM_WAIT: memstall = ~MemReadyM_i;
        default:     memstall = 1'b1;
      endcase
    end
  end

  // Memory-wait FSM with watchdog; ERROR is left only through rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      MemTimeout_o <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (MemReqM_i && !MemReadyM_i) begin
            wait_cnt <= WAIT_ONE;
            if (TIMEOUT_VAL <= WAIT_ONE) begin
              state        <= ST_ERROR;
              MemTimeout_o <= 1'b1;
            end else begin
              state <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (MemReadyM_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc >= TIMEOUT_VAL) begin
              state        <= ST_ERROR;
              MemTimeout_o <= 1'b1;
            end
          end
        end
        default: state <= ST_ERROR;
      endcase
    end
  end

  // Shadow copies of the M/W destinations; frozen together with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_m        <= 5'd0;
      rd_w        <= 5'd0;
      reg_write_m <= 1'b0;
      reg_write_w <= 1'b0;
    end else if (!memstall) begin
      rd_m        <= RdE_i;
      reg_write_m <= RegWriteE_i;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Operand forwarding, M newer than W; x0 is never a forwarding source.
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (!rst) begin
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == Rs1E_i))
        ForwardAE_o = 2'b10;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == Rs1E_i))
        ForwardAE_o = 2'b01;
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == Rs2E_i))
        ForwardBE_o = 2'b10;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == Rs2E_i))
        ForwardBE_o = 2'b01;
    end
  end

  // Only a load result is too late to forward into the next instruction.
  always_comb begin
    data_hazard = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                  ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E_i, Rs2E_i, ResultSrcE_i};

  assign ForwardAE_o = 2'b00;
  assign ForwardBE_o = 2'b00;

  function automatic logic src_busy(input logic [4:0] rs,
                                    input logic [4:0] rd_e, input logic we_e,
                                    input logic [4:0] rdm,  input logic wem,
                                    input logic [4:0] rdw,  input logic wew);
    return (rs != 5'd0) &&
           ((we_e && (rd_e == rs)) || (wem && (rdm == rs)) || (wew && (rdw == rs)));
  endfunction

  // Without forwarding, decode waits until no in-flight writer targets its sources.
  always_comb begin
    data_hazard =
      src_busy(Rs1D_i, RdE_i, RegWriteE_i, rd_m, reg_write_m, rd_w, reg_write_w) ||
      src_busy(Rs2D_i, RdE_i, RegWriteE_i, rd_m, reg_write_m, rd_w, reg_write_w);
  end
`endif

  // Stall/flush priority: reset, memory stall, taken branch, data hazard.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    StallW_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    if (rst) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (memstall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      StallW_o = 1'b1;
    end else if (PCSrcE_i) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (data_hazard) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount_o <= '0;
      FlushCount_o <= '0;
    end else begin
      if (StallF_o && (StallCount_o != '1))
        StallCount_o <= StallCount_o + CNT_WIDTH'(1);
      if (FlushE_o && (FlushCount_o != '1))
        FlushCount_o <= FlushCount_o + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire
